// File: rtl/bsg_buf_pipe.sv
// Registered pipeline buffer: moves width_p-bit words through els_p stages with
// valid/ready on the input and valid/yumi on the output. Empty stages always accept data.
module bsg_buf_pipe #(
    parameter int width_p = 64,
    parameter int els_p   = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         v_i,
    output logic                         ready_o,
    output logic [width_p-1:0]           data_o,
    output logic                         v_o,
    input  logic                         yumi_i,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int cnt_w = $clog2(els_p + 1);

    if (els_p < 1) begin : g_els_check
        $error("bsg_buf_pipe: els_p must be at least 1");
    end

    logic [els_p-1:0]   v_r;
    logic [width_p-1:0] data_r [els_p];

    logic [els_p:0]     en;
    logic [els_p-1:0]   in_v;
    logic [width_p-1:0] in_d [els_p];
    logic [cnt_w-1:0]   cnt;

    // A stage may load when it is empty or when its occupant moves on; this
    // ripples from the consumer back to the input, collapsing bubbles.
    always_comb begin
        en = '0;
        en[els_p] = yumi_i;
        for (int k = els_p - 1; k >= 0; k--) begin
            en[k] = ~v_r[k] | en[k+1];
        end
    end

    always_comb begin
        in_v[0] = v_i;
        in_d[0] = data_i;
        for (int k = 1; k < els_p; k++) begin
            in_v[k] = v_r[k-1];
            in_d[k] = data_r[k-1];
        end
    end

    always_comb begin
        cnt = '0;
        for (int k = 0; k < els_p; k++) begin
            cnt = cnt + cnt_w'(v_r[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_r <= '0;
            for (int k = 0; k < els_p; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < els_p; k++) begin
                if (en[k]) begin
                    v_r[k] <= in_v[k];
                    // Data only moves with a valid word so bubbles do not disturb it.
                    if (in_v[k]) begin
                        data_r[k] <= in_d[k];
                    end
                end
            end
        end
    end

    assign ready_o = en[0] & ~reset_i;
    assign v_o     = v_r[els_p-1] & ~reset_i;
    assign data_o  = reset_i ? '0 : data_r[els_p-1];
    assign count_o = reset_i ? '0 : cnt;

    a_yumi_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
        else $error("bsg_buf_pipe: yumi_i asserted while v_o is low");

    a_ctrl_known: assert property (@(posedge clk_i) disable iff (reset_i) !$isunknown({v_i, yumi_i}))
        else $error("bsg_buf_pipe: unknown value on v_i or yumi_i");

endmodule

// File: tb/tb_bsg_buf_pipe.sv
// Directed and randomised checks of bsg_buf_pipe at els_p = 3, 1 and 8.
module tb_bsg_buf_pipe;

    logic        clk;
    logic        reset;
    logic [63:0] din  [3];
    logic        v_in [3];
    logic        yumi [3];
    logic        rdy  [3];
    logic        vo   [3];
    logic [63:0] dout [3];
    logic [1:0]  count3;
    logic [0:0]  count1;
    logic [3:0]  count8;

    int n_chk;
    int n_pass;

    bsg_buf_pipe #(.width_p(64), .els_p(3)) u_dut3 (
        .clk_i(clk), .reset_i(reset), .data_i(din[0]), .v_i(v_in[0]), .ready_o(rdy[0]),
        .data_o(dout[0]), .v_o(vo[0]), .yumi_i(yumi[0]), .count_o(count3)
    );

    bsg_buf_pipe #(.width_p(64), .els_p(1)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .data_i(din[1]), .v_i(v_in[1]), .ready_o(rdy[1]),
        .data_o(dout[1]), .v_o(vo[1]), .yumi_i(yumi[1]), .count_o(count1)
    );

    bsg_buf_pipe #(.width_p(64), .els_p(8)) u_dut8 (
        .clk_i(clk), .reset_i(reset), .data_i(din[2]), .v_i(v_in[2]), .ready_o(rdy[2]),
        .data_o(dout[2]), .v_o(vo[2]), .yumi_i(yumi[2]), .count_o(count8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cnt_of(int i);
        case (i)
            0:       return int'(count3);
            1:       return int'(count1);
            default: return int'(count8);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        v_in[0] = 1'b1;
        din[0] = 64'hFFFF;
        tick();
        @(negedge clk);
        n_chk++; if (rdy[0] !== 1'b0) $display("FAIL rst_ready: got %b want 0", rdy[0]); else n_pass++;
        n_chk++; if (vo[0] !== 1'b0) $display("FAIL rst_vo: got %b want 0", vo[0]); else n_pass++;
        n_chk++; if (count3 !== 2'd0) $display("FAIL rst_count: got %0d want 0", count3); else n_pass++;
        n_chk++; if (dout[0] !== 64'd0) $display("FAIL rst_data: got %h want 0", dout[0]); else n_pass++;
        tick();
        reset = 1'b0;
        v_in[0] = 1'b0;
        din[0] = 64'd0;
        @(negedge clk);
        n_chk++; if (rdy[0] !== 1'b1) $display("FAIL idle_ready: got %b want 1", rdy[0]); else n_pass++;
        n_chk++; if (vo[0] !== 1'b0) $display("FAIL idle_vo: got %b want 0", vo[0]); else n_pass++;
        n_chk++; if (count3 !== 2'd0) $display("FAIL idle_count: got %0d want 0", count3); else n_pass++;
        n_chk++; if (dout[0] !== 64'd0) $display("FAIL idle_data: got %h want 0", dout[0]); else n_pass++;
        tick();
    endtask

    task automatic test_single_latency();
        v_in[0] = 1'b1;
        din[0] = 64'hDEAD_BEEF_0123_4567;
        @(negedge clk);
        n_chk++; if (rdy[0] !== 1'b1) $display("FAIL lat_accept: got %b want 1", rdy[0]); else n_pass++;
        tick();
        v_in[0] = 1'b0;
        din[0] = 64'd0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            n_chk++; if (vo[0] !== 1'b0) $display("FAIL lat_early_vo c%0d: got %b want 0", c, vo[0]); else n_pass++;
            tick();
        end
        @(negedge clk);
        n_chk++; if (vo[0] !== 1'b1) $display("FAIL lat_vo: got %b want 1", vo[0]); else n_pass++;
        n_chk++; if (dout[0] !== 64'hDEAD_BEEF_0123_4567) $display("FAIL lat_data: got %h want deadbeef01234567", dout[0]); else n_pass++;
        n_chk++; if (count3 !== 2'd1) $display("FAIL lat_count: got %0d want 1", count3); else n_pass++;
        n_chk++; if (rdy[0] !== 1'b1) $display("FAIL lat_ready: got %b want 1", rdy[0]); else n_pass++;
        yumi[0] = 1'b1;
        tick();
        yumi[0] = 1'b0;
        @(negedge clk);
        n_chk++; if (vo[0] !== 1'b0) $display("FAIL lat_drained_vo: got %b want 0", vo[0]); else n_pass++;
        n_chk++; if (count3 !== 2'd0) $display("FAIL lat_drained_count: got %0d want 0", count3); else n_pass++;
        tick();
    endtask

    task automatic test_fill_stall();
        for (int c = 1; c <= 3; c++) begin
            v_in[0] = 1'b1;
            din[0] = 64'(c);
            @(negedge clk);
            n_chk++; if (rdy[0] !== 1'b1) $display("FAIL fill_ready w%0d: got %b want 1", c, rdy[0]); else n_pass++;
            tick();
        end
        din[0] = 64'd4;
        @(negedge clk);
        n_chk++; if (count3 !== 2'd3) $display("FAIL stall_count: got %0d want 3", count3); else n_pass++;
        n_chk++; if (rdy[0] !== 1'b0) $display("FAIL stall_ready: got %b want 0", rdy[0]); else n_pass++;
        n_chk++; if (dout[0] !== 64'd1) $display("FAIL stall_head: got %h want 1", dout[0]); else n_pass++;
        tick();
        yumi[0] = 1'b1;
        @(negedge clk);
        n_chk++; if (rdy[0] !== 1'b1) $display("FAIL full_yumi_ready: got %b want 1", rdy[0]); else n_pass++;
        tick();
        v_in[0] = 1'b0;
        din[0] = 64'd0;
        for (int w = 2; w <= 4; w++) begin
            @(negedge clk);
            n_chk++; if (vo[0] !== 1'b1) $display("FAIL drain_vo w%0d: got %b want 1", w, vo[0]); else n_pass++;
            n_chk++; if (dout[0] !== 64'(w)) $display("FAIL drain_data w%0d: got %h want %h", w, dout[0], 64'(w)); else n_pass++;
            n_chk++; if (count3 !== 2'(w == 2 ? 3 : 5 - w)) $display("FAIL drain_count w%0d: got %0d", w, count3); else n_pass++;
            tick();
        end
        yumi[0] = 1'b0;
        @(negedge clk);
        n_chk++; if (vo[0] !== 1'b0) $display("FAIL drain_empty_vo: got %b want 0", vo[0]); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 103; c++) begin
            v_in[0] = (c < 100);
            din[0] = (c < 100) ? 64'(c) : 64'd0;
            yumi[0] = (c >= 3);
            @(negedge clk);
            if (c < 100) begin
                n_chk++; if (rdy[0] !== 1'b1) $display("FAIL b2b_ready c%0d: got %b want 1", c, rdy[0]); else n_pass++;
            end
            if (c < 3) begin
                n_chk++; if (vo[0] !== 1'b0) $display("FAIL b2b_vo_early c%0d: got %b want 0", c, vo[0]); else n_pass++;
            end else begin
                n_chk++; if (vo[0] !== 1'b1) $display("FAIL b2b_vo c%0d: got %b want 1", c, vo[0]); else n_pass++;
                n_chk++; if (dout[0] !== 64'(c - 3)) $display("FAIL b2b_data c%0d: got %h want %h", c, dout[0], 64'(c - 3)); else n_pass++;
                n_chk++; if (int'(count3) != ((c < 100) ? 3 : 103 - c)) $display("FAIL b2b_count c%0d: got %0d", c, count3); else n_pass++;
            end
            tick();
        end
        v_in[0] = 1'b0;
        yumi[0] = 1'b0;
        @(negedge clk);
        n_chk++; if (count3 !== 2'd0) $display("FAIL b2b_end_count: got %0d want 0", count3); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            v_in[0] = 1'b1;
            din[0] = 64'hA0 + 64'(c);
            tick();
        end
        din[0] = 64'hC0;
        @(negedge clk);
        n_chk++; if (count3 !== 2'd2) $display("FAIL mid_pre_count: got %0d want 2", count3); else n_pass++;
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_chk++; if (rdy[0] !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", rdy[0]); else n_pass++;
        tick();
        reset = 1'b0;
        v_in[0] = 1'b0;
        din[0] = 64'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_chk++; if (vo[0] !== 1'b0) $display("FAIL mid_vo c%0d: got %b want 0", c, vo[0]); else n_pass++;
            n_chk++; if (count3 !== 2'd0) $display("FAIL mid_count c%0d: got %0d want 0", c, count3); else n_pass++;
            tick();
        end
        v_in[0] = 1'b1;
        din[0] = 64'h5A5A;
        tick();
        v_in[0] = 1'b0;
        din[0] = 64'd0;
        tick();
        tick();
        @(negedge clk);
        n_chk++; if (vo[0] !== 1'b1) $display("FAIL mid_fresh_vo: got %b want 1", vo[0]); else n_pass++;
        n_chk++; if (dout[0] !== 64'h5A5A) $display("FAIL mid_fresh_data: got %h want 5a5a", dout[0]); else n_pass++;
        n_chk++; if (count3 !== 2'd1) $display("FAIL mid_fresh_count: got %0d want 1", count3); else n_pass++;
        yumi[0] = 1'b1;
        tick();
        yumi[0] = 1'b0;
    endtask

    task automatic test_random();
        int          els [3];
        int          sz  [3];
        int          hd  [3];
        logic [63:0] md  [3][16];
        int          ms  [3][16];
        bit          mvo [3];
        bit          mrdy;
        int          edges;
        int          seq;
        int          fail0;
        els = '{3, 1, 8};
        for (int i = 0; i < 3; i++) begin
            sz[i] = 0;
            hd[i] = 0;
        end
        edges = 0;
        seq = 0;
        fail0 = n_chk - n_pass;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 3; i++) begin
                // Oldest word only waits for its trip through the stages.
                mvo[i] = (sz[i] > 0) && (edges - ms[i][hd[i]] >= els[i] - 1);
                v_in[i] = 1'($urandom_range(0, 1));
                yumi[i] = mvo[i] & 1'($urandom_range(0, 1));
                seq++;
                din[i] = {8'(i), 24'd0, 32'(seq)};
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_chk++; if (vo[i] !== mvo[i]) $display("FAIL rnd_vo p%0d c%0d: got %b want %b", i, c, vo[i], mvo[i]); else n_pass++;
                if (mvo[i]) begin
                    n_chk++; if (dout[i] !== md[i][hd[i]]) $display("FAIL rnd_data p%0d c%0d: got %h want %h", i, c, dout[i], md[i][hd[i]]); else n_pass++;
                end
                n_chk++; if (cnt_of(i) != sz[i]) $display("FAIL rnd_count p%0d c%0d: got %0d want %0d", i, c, cnt_of(i), sz[i]); else n_pass++;
                mrdy = (sz[i] < els[i]) || yumi[i];
                n_chk++; if (rdy[i] !== mrdy) $display("FAIL rnd_ready p%0d c%0d: got %b want %b", i, c, rdy[i], mrdy); else n_pass++;
            end
            tick();
            edges++;
            for (int i = 0; i < 3; i++) begin
                mrdy = (sz[i] < els[i]) || yumi[i];
                if (yumi[i]) begin
                    hd[i] = (hd[i] + 1) % 16;
                    sz[i]--;
                end
                if (v_in[i] && mrdy) begin
                    md[i][(hd[i] + sz[i]) % 16] = din[i];
                    ms[i][(hd[i] + sz[i]) % 16] = edges;
                    sz[i]++;
                end
            end
            if (n_chk - n_pass - fail0 > 20) break;
        end
        for (int i = 0; i < 3; i++) begin
            v_in[i] = 1'b0;
            yumi[i] = 1'b0;
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din[i] = 64'd0;
            v_in[i] = 1'b0;
            yumi[i] = 1'b0;
        end
        test_reset();
        test_single_latency();
        test_fill_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bsg_buf_pipe.md
Name: bsg_buf_pipe

Overview:
- Parametrised, registered successor to the plain combinational buffer.
- Moves a width_p-bit word through els_p register stages, with valid/ready handshaking on the input side and valid/yumi handshaking on the output side.
- Bubbles collapse: an empty stage always accepts new data, so full throughput is kept under intermittent backpressure.
- Used to retime long wide datapaths between blocks without losing words.

Parameters:
- width_p, 64, data word width in bits (>=1).
- els_p, 2, number of register stages (>=1). Elaboration error if 0.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  reset; synchronous, active-high.
- data_i  input  width_p  input word.
- v_i  input  1  input word valid.
- ready_o  output  1  block can accept a word this cycle.
- data_o  output  width_p  output word (last stage).
- v_o  output  1  output word valid.
- yumi_i  input  1  consumer takes the output word this cycle. Legal only when v_o=1.
- count_o  output  $clog2(els_p+1)  number of occupied stages.

Behaviour:
- State per stage k (0 = input side, els_p-1 = output side):
  - v_r[k], data_r[k].
- Reset (reset_i=1 at a clock edge):
  - all v_r cleared; all data_r cleared to 0.
- While reset_i is high:
  - ready_o=0, v_o=0, data_o=0, count_o=0.
  - v_i and yumi_i are ignored.
- Reset asserted mid-operation discards all in-flight words in the next cycle. No partial drain.
- Advance enables (combinational):
  - en[els_p] = yumi_i.
  - en[k] = ~v_r[k] | en[k+1].
  - ready_o = en[0] & ~reset_i.
- Update on each clock edge, when en[k]=1:
  - v_r[k] <= incoming valid, where incoming is v_i for k=0, else v_r[k-1].
  - data_r[k] <= incoming data, loaded only when incoming valid=1; otherwise data_r[k] holds.
- Update when en[k]=0: stage k holds.
- Outputs:
  - v_o = v_r[els_p-1].
  - data_o = data_r[els_p-1].
  - count_o = popcount(v_r).
- Acceptance rules:
  - A word is accepted when v_i & ready_o.
  - If v_i=1 and ready_o=0, the word is not taken; upstream holds it.
- Latency: a word accepted at edge t into an empty pipe gives v_o=1 in the cycle after edge t+els_p-1, i.e. els_p cycles after acceptance.
- Throughput: with yumi_i held high whenever v_o=1, one word per cycle.
- Full (count_o=els_p):
  - yumi_i=0 gives ready_o=0.
  - yumi_i=1 gives ready_o=1 in the same cycle. Accept and dequeue happen simultaneously and count_o is unchanged.
  - There is a combinational path yumi_i -> ready_o through at most els_p gates. This is intentional.
- Empty (count_o=0): v_o=0, ready_o=1.
- Simultaneous accept and dequeue with a partial fill: count_o is unchanged, and every stage downstream of the first bubble shifts.
- Ordering: words leave in acceptance order. No duplication, no loss.
- Protocol assertions (simulation only):
  - yumi_i & ~v_o is an error.
  - X on v_i or yumi_i outside reset is an error.
- Counter arithmetic: count_o saturates naturally at els_p by construction. No wrap is possible.

Test Plan (width_p=64, els_p=3 unless noted):
- Reset then idle: reset_i=1 for 2 cycles, then 0. Expect v_o=0, ready_o=1, count_o=0, data_o=0. During reset expect ready_o=0.
- Single word latency: push 64'hDEAD_BEEF_0123_4567 at cycle 0 with yumi_i=0. Expect v_o=1 at cycle 3 with that data, count_o=1, ready_o=1.
- Fill and stall: push 0x1, 0x2, 0x3, 0x4 on consecutive cycles with yumi_i=0.
  - Expect ready_o=0 once count_o=3; 0x4 is held.
  - Then yumi_i=1 for 4 cycles.
  - Expect output order 0x1, 0x2, 0x3, 0x4, with 0x4 accepted in the same cycle as the first yumi.
- Full throughput: stream 0..99 with v_i=1 and yumi_i=v_o constantly. Expect ready_o=1 every cycle, outputs 0..99 in order, 3-cycle offset, count_o=3 in steady state.
- Random backpressure: random v_i and yumi_i (50%) for 10k cycles against a reference FIFO model. Expect no loss, no duplication, count_o matching the model; repeat with els_p=1 and els_p=8.
- Reset mid-stream: with count_o=2, assert reset_i for 1 cycle. Expect v_o=0 and count_o=0 the following cycle, and no stale word emitted afterwards.
